// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: default word and address widths shared by the loader and its users
package ram_loader_pkg;
    localparam int RL_ADDR_WIDTH = 4;
    localparam int RL_DATA_WIDTH = 16;
    localparam int RL_INST_WIDTH = 16;
endpackage

// File: rtl/ram_loader.sv
// ram_loader: streams instruction/data pairs into RAM from address 0 and verifies
// every location by reading it back one cycle after the write.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = RL_ADDR_WIDTH,
    parameter int DATA_WIDTH = RL_DATA_WIDTH,
    parameter int INST_WIDTH = RL_INST_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   Load_Count,
    input  logic                  Load_Valid,
    output logic                  Load_Ready,
    input  logic [INST_WIDTH-1:0] Load_Inst,
    input  logic [DATA_WIDTH-1:0] Load_Data,
    output logic                  Ram_Inst_Write,
    output logic                  Ram_Data_Write,
    output logic                  Ram_Inst_Read,
    output logic                  Ram_Data_Read,
    output logic [ADDR_WIDTH-1:0] Ram_Addr,
    output logic [ADDR_WIDTH-1:0] Inst_Addr,
    output logic [INST_WIDTH-1:0] Ram_Inst_In,
    output logic [DATA_WIDTH-1:0] Ram_Data_In,
    input  logic [INST_WIDTH-1:0] Ram_Inst_Out,
    input  logic [DATA_WIDTH-1:0] Ram_Data_Out,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_WIDTH-1:0] Err_Addr
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WRITE, S_READ, S_CHECK, S_DONE} state_t;

    // Counts beyond the RAM depth are clamped so the address never wraps
    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d, addr_q, addr_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d, error_q, error_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  start_go, accept, mismatch;

    assign start_go = (state_q == S_IDLE) && Start;
    assign accept   = (state_q == S_WAIT) && Load_Valid;
    assign mismatch = (state_q == S_CHECK) && ((Ram_Inst_Out != inst_q) || (Ram_Data_Out != data_q));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = (Load_Count == '0) ? S_DONE : S_WAIT;
            S_WAIT:  if (Load_Valid) state_d = S_WRITE;
            S_WRITE: state_d = S_READ;
            S_READ:  state_d = S_CHECK;
            S_CHECK: state_d = (addr_q + 1'b1 == count_q) ? S_DONE : S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Load_Ready     = state_q == S_WAIT;
        Ram_Inst_Write = state_q == S_WRITE;
        Ram_Data_Write = state_q == S_WRITE;
        Ram_Inst_Read  = state_q == S_READ;
        Ram_Data_Read  = state_q == S_READ;
        Busy           = state_q inside {S_WAIT, S_WRITE, S_READ, S_CHECK};
        Ram_Addr       = addr_q[ADDR_WIDTH-1:0];
        Inst_Addr      = addr_q[ADDR_WIDTH-1:0];
        Ram_Inst_In    = inst_q;
        Ram_Data_In    = data_q;
        Done           = done_q;
        Error          = error_q;
        Err_Addr       = err_addr_q;
    end

    always_comb begin
        count_d    = start_go ? ((Load_Count > MAX_COUNT) ? MAX_COUNT : Load_Count) : count_q;
        addr_d     = start_go ? '0 : (state_q == S_CHECK) ? addr_q + 1'b1 : addr_q;
        inst_d     = accept ? Load_Inst : inst_q;
        data_d     = accept ? Load_Data : data_q;
        done_d     = (state_d == S_DONE) ? 1'b1 : start_go ? 1'b0 : done_q;
        error_d    = start_go ? 1'b0 : error_q | mismatch;
        // Only the first mismatch of a session is recorded
        err_addr_d = start_go ? '0 : (mismatch && !error_q) ? addr_q[ADDR_WIDTH-1:0] : err_addr_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q    <= '0;
            addr_q     <= '0;
            inst_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            count_q    <= count_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            data_q     <= data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized sessions against a behavioural RAM; a scoreboard
// queue of expected writes is drained by a monitor whenever the loader writes.
module tb_ram_loader;
    import ram_loader_pkg::*;
    localparam int AW = RL_ADDR_WIDTH;
    localparam int DW = RL_DATA_WIDTH;
    localparam int IW = RL_INST_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic          clk = 0, rst_n = 0, start = 0, load_valid = 0;
    logic [AW:0]   load_count = '0;
    logic [IW-1:0] load_inst = '0, ram_ii, ram_io;
    logic [DW-1:0] load_data = '0, ram_di, ram_do;
    logic          load_ready, ram_iw, ram_dw, ram_ir, ram_dr, busy, done, error;
    logic [AW-1:0] ram_addr, inst_addr, err_addr;

    always #5 clk = ~clk;

    ram_loader dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .Load_Count(load_count),
        .Load_Valid(load_valid), .Load_Ready(load_ready), .Load_Inst(load_inst), .Load_Data(load_data),
        .Ram_Inst_Write(ram_iw), .Ram_Data_Write(ram_dw), .Ram_Inst_Read(ram_ir), .Ram_Data_Read(ram_dr),
        .Ram_Addr(ram_addr), .Inst_Addr(inst_addr), .Ram_Inst_In(ram_ii), .Ram_Data_In(ram_di),
        .Ram_Inst_Out(ram_io), .Ram_Data_Out(ram_do),
        .Busy(busy), .Done(done), .Error(error), .Err_Addr(err_addr)
    );

    int tests = 0, fails = 0, strobes = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Synchronous RAM; addresses flagged in corrupt return inverted data
    logic [IW-1:0]    mem_i [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] corrupt = '0;
    always @(posedge clk) begin
        if (ram_iw) mem_i[ram_addr] <= ram_ii;
        if (ram_dw) mem_d[ram_addr] <= ram_di;
        if (ram_ir) ram_io <= mem_i[ram_addr];
        if (ram_dr) ram_do <= corrupt[ram_addr] ? ~mem_d[ram_addr] : mem_d[ram_addr];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [IW-1:0] i;
        logic [DW-1:0] d;
    } wr_t;
    wr_t wq[$];

    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n) begin
            if (ram_iw | ram_dw | ram_ir | ram_dr) strobes++;
            check("addr_equal", inst_addr, ram_addr);
            check("wr_rd_exclusive", (ram_iw | ram_dw) & (ram_ir | ram_dr), 0);
            check("wr_strobe_pair", ram_iw, ram_dw);
            check("rd_strobe_pair", ram_ir, ram_dr);
            if (ram_iw) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0h written, none expected", ram_addr);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", ram_addr, e.a);
                    check("wr_inst", ram_ii, e.i);
                    check("wr_data", ram_di, e.d);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where the pair is being written
    task automatic feed_pair(input int idx, input logic [IW-1:0] ins, input logic [DW-1:0] dat, input int stall);
        int k = 0;
        while (!load_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!load_ready) begin
            check("ready_timeout", load_ready, 1);
            return;
        end
        repeat (stall) begin
            @(negedge clk);
            check("stall_ready", load_ready, 1);
            check("stall_strobe", ram_iw | ram_dw | ram_ir | ram_dr, 0);
        end
        load_inst  = ins;
        load_data  = dat;
        load_valid = 1;
        wq.push_back('{a: idx[AW-1:0], i: ins, d: dat});
        @(negedge clk);
        load_valid = 0;
        check("write_next_cycle", ram_iw, 1);
    endtask

    task automatic run_session(input int cnt, input logic [DEPTH-1:0] cm, input int smin, input int smax,
                               input bit directed, input bit chk_lat);
        int n = (cnt > DEPTH) ? DEPTH : cnt;
        int lat = 0, s0 = strobes, exp_ea = 0;
        bit exp_err = 0;
        corrupt    = cm;
        start      = 1;
        load_count = cnt[AW:0];
        fork
            while (lat < 500) begin
                @(negedge clk);
                lat++;
                if (done) break;
            end
            begin
                @(negedge clk);
                start = 0;
                for (int i = 0; i < n; i++)
                    if (directed) feed_pair(i, IW'(i + 1), DW'((i + 1) * 17), $urandom_range(smin, smax));
                    else feed_pair(i, IW'($urandom), DW'($urandom), $urandom_range(smin, smax));
            end
        join
        for (int j = 0; j < n; j++)
            if (cm[j] && !exp_err) begin
                exp_err = 1;
                exp_ea  = j;
            end
        check("done", done, 1);
        check("busy_in_done", busy, 0);
        if (chk_lat) check("done_latency", lat, (n == 0) ? 1 : 4 * n + 1);
        check("error", error, exp_err);
        check("err_addr", err_addr, exp_ea);
        check("all_writes_seen", wq.size(), 0);
        if (n == 0) check("no_strobes", strobes - s0, 0);
        @(negedge clk);
        check("done_held", done, 1);
        check("busy_idle", busy, 0);
        wq.delete();
    endtask

    initial begin
        logic [DEPTH-1:0] m;
        int c, sm;
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [DEPTH-1:0] m;
        int c, sm;
        @(negedge clk);
        check("rst_ready", load_ready, 0);
        check("rst_strobes", {ram_iw, ram_dw, ram_ir, ram_dr}, 0);
        check("rst_addr", {ram_addr, inst_addr}, 0);
        check("rst_wdata", {ram_ii, ram_di}, 0);
        check("rst_status", {busy, done, error}, 0);
        check("rst_err_addr", err_addr, 0);
        rst_n = 1;
        repeat (5) begin
            @(negedge clk);
            check("idle_strobes", {ram_iw, ram_dw, ram_ir, ram_dr}, 0);
            check("idle_ready", load_ready, 0);
        end
        run_session(4, '0, 0, 0, 1, 1);
        run_session(0, '0, 0, 0, 0, 1);
        run_session(4, DEPTH'(1) << 2, 0, 0, 1, 1);
        run_session(3, '0, 10, 10, 1, 0);
        run_session(20, (DEPTH'(1) << 3) | (DEPTH'(1) << 15), 0, 0, 0, 1);

        // Reset pulse while address 1 is being written
        start      = 1;
        load_count = 4;
        @(negedge clk);
        start = 0;
        feed_pair(0, 'h5, 'h55, 0);
        feed_pair(1, 'h6, 'h66, 0);
        check("reset_wr_addr", ram_addr, 1);
        #2 rst_n = 0;
        #1;
        check("reset_strobes", {ram_iw, ram_dw, ram_ir, ram_dr}, 0);
        check("reset_status", {busy, done, error, load_ready}, 0);
        wq.delete();
        @(negedge clk);
        rst_n = 1;
        run_session(2, '0, 0, 0, 0, 1);

        for (int s = 0; s < 10; s++) begin
            for (int j = 0; j < DEPTH; j++) m[j] = ($urandom_range(0, 7) == 0);
            c  = $urandom_range(0, 20);
            sm = $urandom_range(0, 3);
            run_session(c, m, 0, sm, 0, sm == 0);
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
